// File: rtl/controle_rega_pkg.sv
// rtl/controle_rega_pkg.sv - state and request codes shared by the irrigation control path
package controle_rega_pkg;

  typedef enum logic [2:0] {
    S_IDLE        = 3'b000,
    S_CONFIRMA    = 3'b001,
    S_ASPERSAO    = 3'b010,
    S_GOTEJAMENTO = 3'b011,
    S_PAUSA       = 3'b100,
    S_ERRO        = 3'b101
  } estado_t;

  localparam logic [1:0] REQ_NONE   = 2'b00;
  localparam logic [1:0] REQ_ASP    = 2'b10;
  localparam logic [1:0] REQ_GOT    = 2'b01;
  localparam logic [1:0] REQ_ILEGAL = 2'b11;

  function automatic logic req_valida(input logic [1:0] req);
    return (req == REQ_ASP) || (req == REQ_GOT);
  endfunction

endpackage

// File: rtl/controle_rega_if.sv
// rtl/controle_rega_if.sv - request/fault inputs and valve/status outputs of the irrigation controller
interface controle_rega_if #(
  parameter int CW = 8
);
  logic [1:0]    rega;
  logic          erro;
  logic          reconhece;
  logic          valvula_asp;
  logic          valvula_got;
  logic          ativo;
  logic          erro_trav;
  logic [2:0]    estado;
  logic [CW-1:0] restante;

  modport master (
    output rega, erro, reconhece,
    input  valvula_asp, valvula_got, ativo, erro_trav, estado, restante
  );

  modport slave (
    input  rega, erro, reconhece,
    output valvula_asp, valvula_got, ativo, erro_trav, estado, restante
  );
endinterface

// File: rtl/controle_rega_temporizador.sv
// rtl/controle_rega_temporizador.sv - loadable down-counter timing the confirm, irrigate and pause phases
module temporizador_rega #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_load,
  input  logic [CW-1:0] i_valor,
  input  logic          i_dec,
  output logic          o_zero,
  output logic [CW-1:0] o_valor
);

  logic [CW-1:0] r_cont;

  // Decrement saturates at zero so a stray enable can never wrap the counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cont <= '0;
    end else if (i_load) begin
      r_cont <= i_valor;
    end else if (i_dec && (r_cont != '0)) begin
      r_cont <= r_cont - 1'b1;
    end
  end

  assign o_zero  = (r_cont == '0);
  assign o_valor = r_cont;

endmodule

// File: rtl/controle_rega.sv
// rtl/controle_rega.sv - turns a validated irrigation request into a timed valve cycle with latched faults
module controle_rega
  import controle_rega_pkg::*;
#(
  parameter int N_CONF  = 4,
  parameter int T_ASP   = 20,
  parameter int T_GOT   = 40,
  parameter int T_PAUSA = 10,
  parameter int CW      = 8
) (
  input  logic           clk,
  input  logic           reset,
  controle_rega_if.slave bus
);

  localparam logic [CW-1:0] L_CONF  = CW'(N_CONF - 1);
  localparam logic [CW-1:0] L_ASP   = CW'(T_ASP - 1);
  localparam logic [CW-1:0] L_GOT   = CW'(T_GOT - 1);
  localparam logic [CW-1:0] L_PAUSA = CW'(T_PAUSA - 1);

  estado_t       r_estado;
  estado_t       w_prox;
  logic [1:0]    r_tipo;
  logic [1:0]    w_tipo;
  logic          w_load;
  logic          w_dec;
  logic          w_zero;
  logic [CW-1:0] w_valor;
  logic [CW-1:0] w_restante;

  temporizador_rega #(.CW(CW)) u_temporizador (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_load),
    .i_valor (w_valor),
    .i_dec   (w_dec),
    .o_zero  (w_zero),
    .o_valor (w_restante)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_estado <= S_IDLE;
      r_tipo   <= REQ_NONE;
    end else begin
      r_estado <= w_prox;
      r_tipo   <= w_tipo;
    end
  end

  always_comb begin
    w_prox  = r_estado;
    w_tipo  = r_tipo;
    w_load  = 1'b0;
    w_valor = '0;
    w_dec   = 1'b0;

    // A fault outranks every other transition, including counter expiry.
    if ((r_estado != S_ERRO) && (bus.erro || (bus.rega == REQ_ILEGAL))) begin
      w_prox = S_ERRO;
      w_tipo = REQ_NONE;
      w_load = 1'b1;
    end else begin
      case (r_estado)
        S_IDLE: begin
          if (req_valida(bus.rega)) begin
            w_prox  = S_CONFIRMA;
            w_tipo  = bus.rega;
            w_load  = 1'b1;
            w_valor = L_CONF;
          end
        end
        S_CONFIRMA: begin
          if (bus.rega != r_tipo) begin
            w_prox = S_IDLE;
          end else if (w_zero) begin
            w_load = 1'b1;
            if (r_tipo == REQ_ASP) begin
              w_prox  = S_ASPERSAO;
              w_valor = L_ASP;
            end else begin
              w_prox  = S_GOTEJAMENTO;
              w_valor = L_GOT;
            end
          end else begin
            w_dec = 1'b1;
          end
        end
        S_ASPERSAO, S_GOTEJAMENTO: begin
          // Any change of request, including a switch to the other valve, is a withdrawal.
          if (w_zero || (bus.rega != r_tipo)) begin
            w_prox  = S_PAUSA;
            w_load  = 1'b1;
            w_valor = L_PAUSA;
          end else begin
            w_dec = 1'b1;
          end
        end
        S_PAUSA: begin
          if (w_zero) begin
            w_prox = S_IDLE;
          end else begin
            w_dec = 1'b1;
          end
        end
        S_ERRO: begin
          w_tipo = REQ_NONE;
          w_load = 1'b1;
          if (bus.reconhece && !bus.erro && (bus.rega != REQ_ILEGAL)) begin
            w_prox = S_IDLE;
          end
        end
        default: begin
          w_prox = S_IDLE;
          w_tipo = REQ_NONE;
          w_load = 1'b1;
        end
      endcase
    end
  end

  assign bus.valvula_asp = (r_estado == S_ASPERSAO);
  assign bus.valvula_got = (r_estado == S_GOTEJAMENTO);
  assign bus.ativo       = (r_estado == S_CONFIRMA) || (r_estado == S_ASPERSAO) ||
                           (r_estado == S_GOTEJAMENTO) || (r_estado == S_PAUSA);
  assign bus.erro_trav   = (r_estado == S_ERRO);
  assign bus.estado      = r_estado;
  assign bus.restante    = w_restante;

endmodule

// File: tb/tb_controle_rega.sv
// tb/tb_controle_rega.sv - directed and randomized bench for controle_rega against a behavioural model
module tb_controle_rega;

  localparam int N_CONF  = 4;
  localparam int T_ASP   = 20;
  localparam int T_GOT   = 40;
  localparam int T_PAUSA = 10;
  localparam int CW      = 8;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  controle_rega_if #(.CW(CW)) bus ();

  controle_rega #(
    .N_CONF  (N_CONF),
    .T_ASP   (T_ASP),
    .T_GOT   (T_GOT),
    .T_PAUSA (T_PAUSA),
    .CW      (CW)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model phases: 0 idle, 1 confirming, 2 sprinkler, 3 drip, 4 pause, 5 fault.
  int         m_st;
  int         m_cnt;
  logic [1:0] m_tipo;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st   = 0;
    m_cnt  = 0;
    m_tipo = 2'b00;
  endtask

  task automatic model_step(input logic [1:0] r, input logic e, input logic ack);
    if (m_st != 5 && (e || r == 2'b11)) begin
      m_st = 5; m_cnt = 0; m_tipo = 2'b00;
    end else begin
      case (m_st)
        0: if (r == 2'b10 || r == 2'b01) begin
             m_st = 1; m_tipo = r; m_cnt = N_CONF - 1;
           end
        1: if (r != m_tipo) m_st = 0;
           else if (m_cnt == 0) begin
             m_st  = (m_tipo == 2'b10) ? 2 : 3;
             m_cnt = (m_tipo == 2'b10) ? T_ASP - 1 : T_GOT - 1;
           end else m_cnt--;
        2, 3: if (m_cnt == 0 || r != m_tipo) begin
                m_st = 4; m_cnt = T_PAUSA - 1;
              end else m_cnt--;
        4: if (m_cnt == 0) m_st = 0; else m_cnt--;
        default: if (ack && !e && r != 2'b11) m_st = 0;
      endcase
    end
  endtask

  task automatic check_all(input string ctx);
    check_eq({ctx, ".estado"}, 32'(bus.estado), 32'(m_st));
    check_eq({ctx, ".restante"}, 32'(bus.restante), 32'(m_cnt));
    check_eq({ctx, ".saidas"},
             32'({bus.valvula_asp, bus.valvula_got, bus.ativo, bus.erro_trav}),
             32'({m_st == 2, m_st == 3, (m_st >= 1 && m_st <= 4), m_st == 5}));
  endtask

  task automatic step(input logic [1:0] r, input logic e, input logic ack);
    bus.rega      = r;
    bus.erro      = e;
    bus.reconhece = ack;
    @(posedge clk);
    model_step(r, e, ack);
    @(negedge clk);
    check_all("passo");
  endtask

  task automatic go_idle();
    repeat (12) step(2'b00, 1'b0, 1'b1);
  endtask

  initial begin
    int lat, on, pa, len;
    logic [1:0] r;
    bus.rega = 2'b00; bus.erro = 1'b0; bus.reconhece = 1'b0;
    model_reset();
    @(negedge clk);
    check_all("reset");
    reset = 1'b0;

    // Full sprinkler cycle with the request held throughout.
    go_idle();
    lat = 0;
    do begin
      step(2'b10, 1'b0, 1'b0);
      lat++;
    end while (!bus.valvula_asp && lat < 60);
    check_eq("latencia_asp", 32'(lat), 32'(N_CONF + 1));
    on = 1;
    for (int i = 0; i < 200; i++) begin
      step(2'b10, 1'b0, 1'b0);
      if (bus.valvula_asp) on++; else break;
    end
    check_eq("duracao_asp", 32'(on), 32'(T_ASP));
    pa = (bus.estado == 3'b100) ? 1 : 0;
    for (int i = 0; i < 200; i++) begin
      step(2'b10, 1'b0, 1'b0);
      if (bus.estado == 3'b100) pa++; else break;
    end
    check_eq("duracao_pausa", 32'(pa), 32'(T_PAUSA));
    repeat (3) step(2'b10, 1'b0, 1'b0);

    // Bounce during confirmation.
    go_idle();
    repeat (2) step(2'b01, 1'b0, 1'b0);
    repeat (2) step(2'b00, 1'b0, 1'b0);

    // Early withdrawal of a drip cycle.
    go_idle();
    repeat (N_CONF + 1) step(2'b01, 1'b0, 1'b0);
    repeat (15) step(2'b01, 1'b0, 1'b0);
    step(2'b00, 1'b0, 1'b0);
    check_eq("got_retirada", 32'(bus.valvula_got), 32'd0);
    repeat (12) step(2'b00, 1'b0, 1'b0);

    // Fault pulse during sprinkling, acknowledge while fault present, then clean acknowledge.
    go_idle();
    repeat (N_CONF + 4) step(2'b10, 1'b0, 1'b0);
    step(2'b10, 1'b1, 1'b0);
    step(2'b10, 1'b1, 1'b1);
    step(2'b10, 1'b0, 1'b0);
    step(2'b10, 1'b0, 1'b1);
    step(2'b00, 1'b0, 1'b0);

    // Illegal code from IDLE and from CONFIRMA.
    go_idle();
    step(2'b11, 1'b0, 1'b0);
    step(2'b11, 1'b0, 1'b1);
    step(2'b00, 1'b0, 1'b1);
    step(2'b10, 1'b0, 1'b0);
    step(2'b11, 1'b0, 1'b0);
    step(2'b00, 1'b0, 1'b1);

    // Asynchronous reset between edges while the sprinkler is open.
    go_idle();
    repeat (N_CONF + 3) step(2'b10, 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1;
    check_eq("reset_assincrono",
             32'({bus.estado, bus.restante, bus.valvula_asp, bus.valvula_got, bus.ativo, bus.erro_trav}),
             32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    check_all("pos_reset");

    // Randomized request bursts with occasional faults and acknowledges.
    for (int b = 0; b < 300; b++) begin
      case ($urandom_range(0, 15))
        0, 1, 2, 3, 4, 5:    r = 2'b00;
        6, 7, 8, 9, 10:      r = 2'b10;
        11, 12, 13, 14:      r = 2'b01;
        default:             r = 2'b11;
      endcase
      len = $urandom_range(1, 25);
      for (int c = 0; c < len; c++)
        step(r, ($urandom_range(0, 59) == 0), ($urandom_range(0, 5) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
